// File: rtl/pic_return_stack.sv
// pic_return_stack: PIC16C5x-style shift-register return-address stack with level tracking.
// Optional sticky overflow/underflow flags and event pulse when `define PC_STACK_ERR_EN is set.
module pic_return_stack #(
    parameter int PC_WIDTH  = 11,
    parameter int STK_DEPTH = 2,
    parameter int LVL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           stk_cmd,
    input  logic [PC_WIDTH-1:0]  pc_in,
    output logic [PC_WIDTH-1:0]  tos_out,
    output logic [LVL_WIDTH-1:0] level,
    output logic                 full,
    output logic                 empty,
    input  logic                 err_clr,
    output logic                 ovf_flag,
    output logic                 unf_flag,
    output logic                 err_pulse
);

    localparam logic [1:0]           STK_PUSH = 2'b01;
    localparam logic [1:0]           STK_POP  = 2'b10;
    localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(STK_DEPTH);
    localparam logic [LVL_WIDTH-1:0] LVL_ONE  = LVL_WIDTH'(1);

    if (STK_DEPTH < 2) begin : g_bad_depth
        $error("pic_return_stack: STK_DEPTH must be >= 2");
    end
    if ((1 << LVL_WIDTH) <= STK_DEPTH) begin : g_bad_lvl_width
        $error("pic_return_stack: LVL_WIDTH too narrow for STK_DEPTH");
    end

    logic [STK_DEPTH-1:0][PC_WIDTH-1:0] lvl_q, lvl_d;
    logic [LVL_WIDTH-1:0]               level_q, level_d;
    logic                               ovf_evt, unf_evt;

    // The array always shifts on a command; only the level counter saturates.
    always_comb begin
        lvl_d   = lvl_q;
        level_d = level_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        case (stk_cmd)
            STK_PUSH: begin
                lvl_d[0] = pc_in;
                for (int i = 1; i < STK_DEPTH; i++) begin
                    lvl_d[i] = lvl_q[i-1];
                end
                if (level_q == LVL_FULL) begin
                    ovf_evt = 1'b1;
                end else begin
                    level_d = level_q + LVL_ONE;
                end
            end
            STK_POP: begin
                // Bottom entry is kept, so repeated pops replicate it.
                for (int i = 0; i < STK_DEPTH - 1; i++) begin
                    lvl_d[i] = lvl_q[i+1];
                end
                if (level_q == '0) begin
                    unf_evt = 1'b1;
                end else begin
                    level_d = level_q - LVL_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q   <= '0;
            level_q <= '0;
        end else begin
            lvl_q   <= lvl_d;
            level_q <= level_d;
        end
    end

    assign tos_out = lvl_q[0];
    assign level   = level_q;
    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == '0);

`ifdef PC_STACK_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic pulse_q, pulse_d;

    // A new event outranks a coincident clear.
    always_comb begin
        ovf_d   = ovf_evt | (ovf_q & ~err_clr);
        unf_d   = unf_evt | (unf_q & ~err_clr);
        pulse_d = ovf_evt | unf_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            pulse_q <= pulse_d;
        end
    end

    assign ovf_flag  = ovf_q;
    assign unf_flag  = unf_q;
    assign err_pulse = pulse_q;
`else
    logic unused_err;
    assign unused_err = err_clr ^ ovf_evt ^ unf_evt;

    assign ovf_flag  = 1'b0;
    assign unf_flag  = 1'b0;
    assign err_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_pic_return_stack.sv
// tb_pic_return_stack: scoreboard bench for pic_return_stack (DEPTH=2, 11-bit PC).
// Flag expectations follow whether PC_STACK_ERR_EN is defined for the build.
module tb_pic_return_stack;

`ifdef PC_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] ILL  = 2'b11;

    typedef struct packed {
        logic [10:0] tos;
        logic [1:0]  lvl;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
        logic        pulse;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  stk_cmd = NOP;
    logic [10:0] pc_in = '0;
    logic        err_clr = 1'b0;
    logic [10:0] tos_out;
    logic [1:0]  level;
    logic        full, empty, ovf_flag, unf_flag, err_pulse;

    int tests_run = 0;
    int tests_failed = 0;

    obs_t exp_q[$];
    obs_t act_q[$];

    // reference model
    logic [10:0] m_l0 = '0, m_l1 = '0;
    int          m_level = 0;
    logic        m_ovf = 1'b0, m_unf = 1'b0, m_pulse = 1'b0;

    pic_return_stack #(.PC_WIDTH(11), .STK_DEPTH(2), .LVL_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .stk_cmd(stk_cmd), .pc_in(pc_in),
        .tos_out(tos_out), .level(level), .full(full), .empty(empty),
        .err_clr(err_clr), .ovf_flag(ovf_flag), .unf_flag(unf_flag),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [1:0] c, input logic [10:0] p, input logic clr);
        obs_t e;
        logic eo, eu;
        rst = r; stk_cmd = c; pc_in = p; err_clr = clr;
        if (r) begin
            m_l0 = '0; m_l1 = '0; m_level = 0;
            m_ovf = 1'b0; m_unf = 1'b0; m_pulse = 1'b0;
        end else begin
            eo = (c == PUSH) && (m_level == 2);
            eu = (c == POP) && (m_level == 0);
            if (c == PUSH) begin
                m_l1 = m_l0; m_l0 = p;
                if (m_level < 2) m_level++;
            end else if (c == POP) begin
                m_l0 = m_l1;
                if (m_level > 0) m_level--;
            end
            if (ERR_EN) begin
                m_ovf = eo | (m_ovf & ~clr);
                m_unf = eu | (m_unf & ~clr);
                m_pulse = eo | eu;
            end
        end
        e.tos = m_l0; e.lvl = 2'(m_level);
        e.full = (m_level == 2); e.empty = (m_level == 0);
        e.ovf = m_ovf; e.unf = m_unf; e.pulse = m_pulse;
        exp_q.push_back(e);
        @(posedge clk); #1;
        act_q.push_back({tos_out, level, full, empty, ovf_flag, unf_flag, err_pulse});
        rst = 1'b0; stk_cmd = NOP; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, a;
        step(1'b1, PUSH, 11'h5A5, 1'b0);
        step(1'b1, PUSH, 11'h2C3, 1'b1);
        tests_run++;
        if (tos_out !== 11'h000 || level !== 2'd0 || empty !== 1'b1 || full !== 1'b0 ||
            ovf_flag !== 1'b0 || unf_flag !== 1'b0 || err_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_const: tos=%h lvl=%0d empty=%b full=%b flags=%b%b%b, want 000/0/1/0/000",
                     tos_out, level, empty, full, ovf_flag, unf_flag, err_pulse);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); tests_run++;
            if (a !== e) begin tests_failed++; $display("FAIL reset: got %h want %h", a, e); end
        end
    endtask

    task automatic test_push_pop();
        obs_t e, a;
        step(1'b0, PUSH, 11'h123, 1'b0);
        step(1'b0, PUSH, 11'h456, 1'b0);
        tests_run++;
        if (tos_out !== 11'h456 || level !== 2'd2 || full !== 1'b1) begin
            tests_failed++;
            $display("FAIL push2_const: tos=%h lvl=%0d full=%b, want 456/2/1", tos_out, level, full);
        end
        step(1'b0, POP, 11'h000, 1'b0);
        tests_run++;
        if (tos_out !== 11'h123 || level !== 2'd1) begin
            tests_failed++;
            $display("FAIL pop1_const: tos=%h lvl=%0d, want 123/1", tos_out, level);
        end
        step(1'b0, POP, 11'h000, 1'b0);
        tests_run++;
        if (level !== 2'd0 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL pop2_const: lvl=%0d empty=%b, want 0/1", level, empty);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); tests_run++;
            if (a !== e) begin tests_failed++; $display("FAIL push_pop: got %h want %h", a, e); end
        end
    endtask

    task automatic test_overflow();
        obs_t e, a;
        step(1'b0, PUSH, 11'h001, 1'b0);
        step(1'b0, PUSH, 11'h002, 1'b0);
        step(1'b0, PUSH, 11'h003, 1'b0);
        tests_run++;
        if (tos_out !== 11'h003 || level !== 2'd2 || ovf_flag !== ERR_EN || err_pulse !== ERR_EN) begin
            tests_failed++;
            $display("FAIL ovf_const: tos=%h lvl=%0d ovf=%b pulse=%b, want 003/2/%b/%b",
                     tos_out, level, ovf_flag, err_pulse, ERR_EN, ERR_EN);
        end
        step(1'b0, NOP, 11'h000, 1'b0);
        tests_run++;
        if (err_pulse !== 1'b0 || ovf_flag !== ERR_EN) begin
            tests_failed++;
            $display("FAIL ovf_pulse_width: pulse=%b ovf=%b, want 0/%b", err_pulse, ovf_flag, ERR_EN);
        end
        step(1'b0, POP, 11'h000, 1'b0);
        step(1'b0, POP, 11'h000, 1'b0);
        tests_run++;
        if (tos_out !== 11'h002 || level !== 2'd0) begin
            tests_failed++;
            $display("FAIL ovf_pop_const: tos=%h lvl=%0d, want 002/0", tos_out, level);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); tests_run++;
            if (a !== e) begin tests_failed++; $display("FAIL overflow: got %h want %h", a, e); end
        end
    endtask

    task automatic test_underflow();
        obs_t e, a;
        step(1'b1, NOP, 11'h000, 1'b0);
        step(1'b0, PUSH, 11'h7FF, 1'b0);
        step(1'b0, PUSH, 11'h7FF, 1'b0);
        step(1'b0, POP, 11'h000, 1'b0);
        step(1'b0, POP, 11'h000, 1'b0);
        step(1'b0, POP, 11'h000, 1'b0);
        step(1'b0, POP, 11'h000, 1'b0);
        tests_run++;
        if (tos_out !== 11'h7FF || level !== 2'd0 || unf_flag !== ERR_EN || err_pulse !== ERR_EN) begin
            tests_failed++;
            $display("FAIL unf_const: tos=%h lvl=%0d unf=%b pulse=%b, want 7FF/0/%b/%b",
                     tos_out, level, unf_flag, err_pulse, ERR_EN, ERR_EN);
        end
        step(1'b0, NOP, 11'h000, 1'b1);
        tests_run++;
        if (unf_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL unf_clr: unf=%b, want 0", unf_flag);
        end
        step(1'b0, POP, 11'h000, 1'b1);
        tests_run++;
        if (unf_flag !== ERR_EN) begin
            tests_failed++;
            $display("FAIL unf_clr_vs_event: unf=%b, want %b", unf_flag, ERR_EN);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); tests_run++;
            if (a !== e) begin tests_failed++; $display("FAIL underflow: got %h want %h", a, e); end
        end
    endtask

    task automatic test_illegal_and_midreset();
        obs_t e, a;
        step(1'b1, NOP, 11'h000, 1'b0);
        step(1'b0, PUSH, 11'h2AA, 1'b0);
        step(1'b0, ILL, 11'h555, 1'b0);
        step(1'b0, ILL, 11'h111, 1'b0);
        step(1'b0, ILL, 11'h0F0, 1'b0);
        tests_run++;
        if (tos_out !== 11'h2AA || level !== 2'd1) begin
            tests_failed++;
            $display("FAIL ill_cmd_const: tos=%h lvl=%0d, want 2AA/1", tos_out, level);
        end
        step(1'b0, PUSH, 11'h155, 1'b0);
        step(1'b1, POP, 11'h000, 1'b0);
        tests_run++;
        if (tos_out !== 11'h000 || level !== 2'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_const: tos=%h lvl=%0d, want 000/0", tos_out, level);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); tests_run++;
            if (a !== e) begin tests_failed++; $display("FAIL illegal: got %h want %h", a, e); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, a;
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 2'($urandom_range(0, 3)), 11'($urandom), ($urandom_range(0, 7) == 0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); tests_run++;
            if (a !== e) begin tests_failed++; $display("FAIL back_to_back: got %h want %h", a, e); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_illegal_and_midreset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
